ps2_lcd_text_buffer: RTL and testbench

Parametrised keyboard-to-LCD text path between PS2_controller and LCD_controller. Buffers PS/2 make codes in a FIFO and translates each through an external 1-cycle-latency PS2_to_LCD ROM. Flushes the buffer to the LCD as character writes, tracking the cursor across COLS x ROWS with automatic line change and wrap. Adds three behaviours: batch or echo mode, backspace editing, and an Enter-forced partial flush.

---
 rtl/ps2_lcd_pkg.sv | 49 ++++
 rtl/ps2_lcd_text_buffer_if.sv | 32 +++
 rtl/lcd_char_fifo.sv | 70 +++++++
 rtl/ps2_lcd_text_buffer.sv | 194 +++++++++++++++++++
 tb/tb_ps2_lcd_text_buffer.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_lcd_pkg.sv
// Shared definitions for the PS/2-to-LCD text path.
//   state_e        : controller states. The init sequence runs first, then the controller
//                    idles, buffering keys, and flushes them as character writes.
//   init_instr()   : the fixed HD44780 power-up instruction list, indexed 0..INIT_LAST.
//   row_base_addr(): DDRAM start address of each display line.
//   DEFAULT_*_CODE : default scan codes for the editing keys.
package ps2_lcd_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_INIT_WAIT,
    S_IDLE,
    S_ROM_WAIT,
    S_ISSUE_CHAR,
    S_FINISH_CHAR,
    S_ISSUE_LINE,
    S_FINISH_LINE
  } state_e;

  // {cmd/data, byte}; bit 8 = 0 selects the instruction register.
  localparam logic [8:0] INIT_FUNCTION_SET = 9'h038;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [8:0] INIT_DISPLAY_ON   = 9'h00C;  // display on, cursor off
  localparam logic [8:0] INIT_CLEAR        = 9'h001;
  localparam logic [8:0] INIT_ENTRY_MODE   = 9'h006;  // increment, no shift
  localparam logic [8:0] INIT_HOME         = 9'h080;  // DDRAM address 0
  localparam logic [2:0] INIT_LAST         = 3'd4;

  localparam logic [7:0] ROW_BASE [4] = '{8'h00, 8'h40, 8'h14, 8'h54};

  localparam logic [7:0] DEFAULT_BKSP_CODE  = 8'h66;
  localparam logic [7:0] DEFAULT_ENTER_CODE = 8'h5A;

  function automatic logic [8:0] init_instr(input logic [2:0] idx);
    logic [8:0] instr;
    case (idx)
      3'd0:    instr = INIT_FUNCTION_SET;
      3'd1:    instr = INIT_DISPLAY_ON;
      3'd2:    instr = INIT_CLEAR;
      3'd3:    instr = INIT_ENTRY_MODE;
      default: instr = INIT_HOME;
    endcase
    return instr;
  endfunction

  function automatic logic [6:0] row_base_addr(input logic [1:0] row);
    return ROW_BASE[row][6:0];
  endfunction

endpackage

// File: rtl/ps2_lcd_text_buffer_if.sv
// LCD command bus and translation-ROM bus of the text buffer.
//   rom_address     : {1'b0, scan code} presented to the PS2_to_LCD ROM
//   rom_q           : LCD character code, valid one cycle after rom_address
//   LCD_start       : one-cycle start pulse to LCD_controller
//   LCD_instruction : {cmd/data, byte}, held until the next issue
//   LCD_done        : LCD_controller completion
// master = text buffer, slave = ROM + LCD_controller side.
interface ps2_lcd_text_buffer_if;

  logic [8:0] rom_address;
  logic [7:0] rom_q;
  logic       LCD_start;
  logic [8:0] LCD_instruction;
  logic       LCD_done;

  modport master (
    output rom_address,
    output LCD_start,
    output LCD_instruction,
    input  rom_q,
    input  LCD_done
  );

  modport slave (
    input  rom_address,
    input  LCD_start,
    input  LCD_instruction,
    output rom_q,
    output LCD_done
  );

endinterface

// File: rtl/lcd_char_fifo.sv
// DEPTH x 8 register FIFO holding buffered scan codes.
//   push_i / push_data_i : append a code as the newest entry
//   pop_oldest_i         : drop the head (the entry just written to the LCD)
//   pop_newest_i         : drop the most recently pushed entry (backspace)
//   head_data_o          : oldest entry, undefined while empty
//   fill_o               : occupancy 0..DEPTH
// The caller never raises two operations in one cycle; full/empty guards keep
// the pointers consistent even if it did.
module lcd_char_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                         CLOCK_50_I,
  input  logic                         resetn,
  input  logic                         push_i,
  input  logic [7:0]                   push_data_i,
  input  logic                         pop_oldest_i,
  input  logic                         pop_newest_i,
  output logic [7:0]                   head_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   fill_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop_oldest, do_pop_newest;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PtrW-1:0] ptr_dec(input logic [PtrW-1:0] p);
    return (p == '0) ? PtrW'(DEPTH - 1) : p - 1'b1;
  endfunction

  assign do_push       = push_i && (count_q != CntW'(DEPTH));
  assign do_pop_oldest = pop_oldest_i && (count_q != '0);
  assign do_pop_newest = pop_newest_i && (count_q != '0);

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (do_push) begin
      tail_q  <= ptr_inc(tail_q);
      count_q <= count_q + 1'b1;
    end else if (do_pop_oldest) begin
      head_q  <= ptr_inc(head_q);
      count_q <= count_q - 1'b1;
    end else if (do_pop_newest) begin
      tail_q  <= ptr_dec(tail_q);
      count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge CLOCK_50_I) begin
    if (do_push) begin
      mem_q[tail_q] <= push_data_i;
    end
  end

  assign head_data_o = mem_q[head_q];
  assign fill_o      = count_q;

endmodule

// File: rtl/ps2_lcd_text_buffer.sv
// Keyboard-to-LCD text path. Initialises the LCD, buffers PS/2 make codes, and
// flushes them (oldest first, through the 1-cycle PS2_to_LCD ROM) as character
// writes while tracking the cursor over COLS x ROWS with line change and wrap.
//   CLOCK_50_I, resetn : clock, asynchronous active-low reset
//   PS2_code, PS2_code_ready, PS2_make_code : PS2_controller outputs; one event
//                        per rising edge of PS2_code_ready when it is a make code
//   lcd                : ROM address/data and LCD_controller start/instruction/done
//   fill_level         : FIFO occupancy
//   busy               : high whenever the controller is not idle
//   drop_pulse         : one-cycle pulse when a make code is discarded
// Batch mode flushes when the FIFO fills; echo mode after every character.
// BKSP_CODE deletes the newest buffered entry, ENTER_CODE flushes what is buffered.
module ps2_lcd_text_buffer
  import ps2_lcd_pkg::*;
#(
  parameter int unsigned COLS       = 16,
  parameter int unsigned ROWS       = 2,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ECHO_MODE  = 0,
  parameter logic [7:0]  BKSP_CODE  = DEFAULT_BKSP_CODE,
  parameter logic [7:0]  ENTER_CODE = DEFAULT_ENTER_CODE
) (
  input  logic                       CLOCK_50_I,
  input  logic                       resetn,
  input  logic [7:0]                 PS2_code,
  input  logic                       PS2_code_ready,
  input  logic                       PS2_make_code,
  ps2_lcd_text_buffer_if.master      lcd,
  output logic [$clog2(DEPTH+1)-1:0] fill_level,
  output logic                       busy,
  output logic                       drop_pulse
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned ColW = $clog2(COLS);
  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_e          state_q, state_d;
  logic [2:0]      init_idx_q, init_idx_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic            start_q, start_d;
  logic [8:0]      instr_q, instr_d;
  logic            drop_q, drop_d;
  logic            ready_q;
  logic            key_event;
  logic            push, pop_oldest, pop_newest;
  logic [7:0]      head_data;
  logic [CntW-1:0] fill;

  lcd_char_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLOCK_50_I   (CLOCK_50_I),
    .resetn       (resetn),
    .push_i       (push),
    .push_data_i  (PS2_code),
    .pop_oldest_i (pop_oldest),
    .pop_newest_i (pop_newest),
    .head_data_o  (head_data),
    .fill_o       (fill)
  );

  // PS2_code_ready is a level; only its rising edge carries a new code.
  assign key_event = PS2_code_ready & ~ready_q & PS2_make_code;

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    col_d      = col_q;
    row_d      = row_q;
    start_d    = 1'b0;
    instr_d    = instr_q;
    drop_d     = 1'b0;
    push       = 1'b0;
    pop_oldest = 1'b0;
    pop_newest = 1'b0;

    unique case (state_q)
      S_INIT: begin
        instr_d = init_instr(init_idx_q);
        start_d = 1'b1;
        state_d = S_INIT_WAIT;
      end

      S_INIT_WAIT: begin
        if (lcd.LCD_done) begin
          if (init_idx_q == INIT_LAST) begin
            init_idx_d = '0;
            col_d      = '0;
            row_d      = '0;
            state_d    = S_IDLE;
          end else begin
            init_idx_d = init_idx_q + 1'b1;
            state_d    = S_INIT;
          end
        end
      end

      S_IDLE: begin
        if (key_event) begin
          if (PS2_code == BKSP_CODE) begin
            pop_newest = (fill != '0);
          end else if (PS2_code == ENTER_CODE) begin
            if (fill != '0) begin
              state_d = S_ROM_WAIT;
            end
          end else if (fill < CntW'(DEPTH)) begin
            push = 1'b1;
            if ((ECHO_MODE != 0) || (fill == CntW'(DEPTH - 1))) begin
              state_d = S_ROM_WAIT;
            end
          end else begin
            // A full FIFO always starts a flush, so this is only a safety net.
            drop_d = 1'b1;
          end
        end
      end

      // The FIFO head already drives rom_address; give rom_q one cycle to follow.
      S_ROM_WAIT: begin
        state_d = S_ISSUE_CHAR;
      end

      S_ISSUE_CHAR: begin
        instr_d = {1'b1, lcd.rom_q};
        start_d = 1'b1;
        state_d = S_FINISH_CHAR;
      end

      S_FINISH_CHAR: begin
        if (lcd.LCD_done) begin
          pop_oldest = 1'b1;
          if (col_q == ColW'(COLS - 1)) begin
            col_d   = '0;
            row_d   = (row_q == RowW'(ROWS - 1)) ? '0 : row_q + 1'b1;
            state_d = S_ISSUE_LINE;
          end else begin
            col_d   = col_q + 1'b1;
            // fill still counts the entry being popped this cycle.
            state_d = (fill > CntW'(1)) ? S_ROM_WAIT : S_IDLE;
          end
        end
      end

      // Wrapping to row 0 simply overwrites the old text.
      S_ISSUE_LINE: begin
        instr_d = {2'b01, row_base_addr(2'(row_q))};
        start_d = 1'b1;
        state_d = S_FINISH_LINE;
      end

      S_FINISH_LINE: begin
        if (lcd.LCD_done) begin
          state_d = (fill != '0) ? S_ROM_WAIT : S_IDLE;
        end
      end
    endcase

    if (key_event && (state_q != S_IDLE)) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_INIT;
      init_idx_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      start_q    <= 1'b0;
      instr_q    <= '0;
      drop_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      col_q      <= col_d;
      row_q      <= row_d;
      start_q    <= start_d;
      instr_q    <= instr_d;
      drop_q     <= drop_d;
      ready_q    <= PS2_code_ready;
    end
  end

  assign lcd.rom_address     = {1'b0, head_data};
  assign lcd.LCD_start       = start_q;
  assign lcd.LCD_instruction = instr_q;
  assign fill_level          = fill;
  assign busy                = (state_q != S_IDLE);
  assign drop_pulse          = drop_q;

endmodule

// File: tb/tb_ps2_lcd_text_buffer.sv
// Bench for ps2_lcd_text_buffer: dut_a uses the default parameters (batch mode),
// dut_b uses COLS=4, ROWS=2, ECHO_MODE=1. Each has a ROM model, an LCD_controller
// model that answers LCD_done 20 cycles after every start, and a monitor that pops
// the expected instruction stream built by a small key/cursor model.
module tb_ps2_lcd_text_buffer;

  localparam int unsigned LcdLat = 20;
  localparam int unsigned Bound  = 5000;
  localparam logic [7:0]  Bksp   = 8'h66;
  localparam logic [7:0]  Enter  = 8'h5A;

  logic CLOCK_50_I = 1'b0;
  logic resetn     = 1'b0;
  always #10 CLOCK_50_I = ~CLOCK_50_I;

  logic [7:0] code_a = '0, code_b = '0;
  logic       rdy_a = 1'b0, rdy_b = 1'b0, make_a = 1'b0, make_b = 1'b0;
  logic [4:0] fill_a, fill_b;
  logic       busy_a, busy_b, drop_a, drop_b;

  ps2_lcd_text_buffer_if bus_a ();
  ps2_lcd_text_buffer_if bus_b ();

  ps2_lcd_text_buffer dut_a (
    .CLOCK_50_I     (CLOCK_50_I),
    .resetn         (resetn),
    .PS2_code       (code_a),
    .PS2_code_ready (rdy_a),
    .PS2_make_code  (make_a),
    .lcd            (bus_a),
    .fill_level     (fill_a),
    .busy           (busy_a),
    .drop_pulse     (drop_a)
  );

  ps2_lcd_text_buffer #(
    .COLS      (4),
    .ROWS      (2),
    .ECHO_MODE (1)
  ) dut_b (
    .CLOCK_50_I     (CLOCK_50_I),
    .resetn         (resetn),
    .PS2_code       (code_b),
    .PS2_code_ready (rdy_b),
    .PS2_make_code  (make_b),
    .lcd            (bus_b),
    .fill_level     (fill_b),
    .busy           (busy_b),
    .drop_pulse     (drop_b)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         chars_a  = 0;
  logic [8:0] exp_a[$], exp_b[$];
  logic [7:0] mdl_a[$], mdl_b[$];
  int         col_m[2], row_m[2];
  logic [8:0] init_seq[5];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rom_fn(input logic [8:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [6:0] base_m(input int row);
    case (row)
      0:       return 7'h00;
      1:       return 7'h40;
      2:       return 7'h14;
      default: return 7'h54;
    endcase
  endfunction

  // ROM model: one cycle of latency.
  always @(posedge CLOCK_50_I) begin
    bus_a.rom_q <= rom_fn(bus_a.rom_address);
    bus_b.rom_q <= rom_fn(bus_b.rom_address);
  end

  // LCD_controller models; a reset abandons the pending completion.
  initial begin : lcd_a
    bus_a.LCD_done = 1'b0;
    forever begin
      @(negedge CLOCK_50_I);
      if (bus_a.LCD_start) begin
        for (int i = 0; i < LcdLat; i++) begin
          @(negedge CLOCK_50_I);
          if (!resetn) break;
        end
        if (resetn) begin
          bus_a.LCD_done = 1'b1;
          @(negedge CLOCK_50_I);
          bus_a.LCD_done = 1'b0;
        end
      end
    end
  end

  initial begin : lcd_b
    bus_b.LCD_done = 1'b0;
    forever begin
      @(negedge CLOCK_50_I);
      if (bus_b.LCD_start) begin
        for (int i = 0; i < LcdLat; i++) begin
          @(negedge CLOCK_50_I);
          if (!resetn) break;
        end
        if (resetn) begin
          bus_b.LCD_done = 1'b1;
          @(negedge CLOCK_50_I);
          bus_b.LCD_done = 1'b0;
        end
      end
    end
  end

  // Monitors: every start pulse must match the head of the expected stream.
  initial begin : mon_a
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge CLOCK_50_I);
      if (bus_a.LCD_start) begin
        check("a_start_gap", prev, 0);
        check("a_write_expected", exp_a.size() != 0, 1);
        if (exp_a.size() != 0) check("a_instr", bus_a.LCD_instruction, exp_a.pop_front());
        if (bus_a.LCD_instruction[8]) chars_a++;
      end
      prev = bus_a.LCD_start;
    end
  end

  initial begin : mon_b
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge CLOCK_50_I);
      if (bus_b.LCD_start) begin
        check("b_start_gap", prev, 0);
        check("b_write_expected", exp_b.size() != 0, 1);
        if (exp_b.size() != 0) check("b_instr", bus_b.LCD_instruction, exp_b.pop_front());
      end
      prev = bus_b.LCD_start;
    end
  end

  task automatic push_exp(input int w, input logic [8:0] v);
    if (w == 0) exp_a.push_back(v);
    else        exp_b.push_back(v);
  endtask

  // Move every modelled FIFO entry into the expected LCD stream, with line changes.
  task automatic model_flush(input int w);
    logic [7:0] c;
    int cols;
    cols = (w == 0) ? 16 : 4;
    while (((w == 0) ? mdl_a.size() : mdl_b.size()) > 0) begin
      if (w == 0) c = mdl_a.pop_front();
      else        c = mdl_b.pop_front();
      push_exp(w, {1'b1, rom_fn({1'b0, c})});
      col_m[w]++;
      if (col_m[w] == cols) begin
        col_m[w] = 0;
        row_m[w] = (row_m[w] + 1) % 2;
        push_exp(w, {2'b01, base_m(row_m[w])});
      end
    end
  endtask

  // Drive one PS/2 code starting at a negedge; check drop_pulse and fill_level.
  task automatic send(input int w, input logic [7:0] c, input logic mk, input logic exp_drop,
                      input int exp_fill, input string tag);
    logic d1, d2;
    logic [4:0] f;
    if (w == 0) begin code_a = c; make_a = mk; rdy_a = 1'b1; end
    else        begin code_b = c; make_b = mk; rdy_b = 1'b1; end
    @(negedge CLOCK_50_I);
    d1 = (w == 0) ? drop_a : drop_b;
    f  = (w == 0) ? fill_a : fill_b;
    if (w == 0) rdy_a = 1'b0;
    else        rdy_b = 1'b0;
    @(negedge CLOCK_50_I);
    d2 = (w == 0) ? drop_a : drop_b;
    check({tag, "_drop"}, d1, exp_drop);
    check({tag, "_drop_end"}, d2, 0);
    check({tag, "_fill"}, f, exp_fill);
  endtask

  // A make code delivered while idle: update the model, then drive it.
  task automatic key(input int w, input logic [7:0] c, input string tag);
    int sz;
    bit fl;
    sz = (w == 0) ? mdl_a.size() : mdl_b.size();
    fl = 1'b0;
    if (c == Bksp) begin
      if (sz > 0) begin
        if (w == 0) void'(mdl_a.pop_back());
        else        void'(mdl_b.pop_back());
        sz--;
      end
    end else if (c == Enter) begin
      fl = (sz > 0);
    end else begin
      if (w == 0) mdl_a.push_back(c);
      else        mdl_b.push_back(c);
      sz++;
      fl = (w == 1) || (sz == 16);
    end
    if (fl) model_flush(w);
    send(w, c, 1'b1, 1'b0, sz, tag);
  endtask

  task automatic wait_idle(input int w, input string tag);
    int n;
    n = 0;
    while (((w == 0) ? busy_a : busy_b) && n < Bound) begin
      @(negedge CLOCK_50_I);
      n++;
    end
    check({tag, "_timeout"}, n < Bound, 1);
  endtask

  task automatic wait_chars(input int target, input string tag);
    int n;
    n = 0;
    while (chars_a < target && n < Bound) begin
      @(negedge CLOCK_50_I);
      n++;
    end
    check({tag, "_timeout"}, n < Bound, 1);
  endtask

  task automatic load_init;
    for (int i = 0; i < 5; i++) begin
      exp_a.push_back(init_seq[i]);
      exp_b.push_back(init_seq[i]);
    end
    col_m = '{0, 0};
    row_m = '{0, 0};
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

  initial begin : main
    int base;
    init_seq = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080};
    load_init();

    // Reset state.
    #5;
    check("rst_start", bus_a.LCD_start, 0);
    check("rst_instr", bus_a.LCD_instruction, 0);
    check("rst_fill", fill_a, 0);
    check("rst_busy", busy_a, 1);
    check("rst_drop", drop_a, 0);
    repeat (3) @(negedge CLOCK_50_I);
    resetn = 1'b1;

    // Init sequence on both instances.
    wait_idle(0, "init_a");
    wait_idle(1, "init_b");
    check("init_a_drained", exp_a.size(), 0);
    check("init_b_drained", exp_b.size(), 0);
    check("init_busy", busy_a, 0);

    // Batch flush of 16 characters, with a make code dropped mid-flush.
    base = chars_a;
    for (int i = 0; i < 16; i++) key(0, 8'h1C, "batch_key");
    wait_chars(base + 3, "drop_wait");
    send(0, 8'h1C, 1'b1, 1'b1, 14, "drop_busy");
    wait_idle(0, "batch");
    check("batch_drained", exp_a.size(), 0);
    check("batch_fill", fill_a, 0);

    // Break code while idle is ignored.
    send(0, 8'h1C, 1'b0, 1'b0, 0, "break_idle");
    check("break_busy", busy_a, 0);

    // Backspace editing and Enter-forced partial flush.
    key(0, 8'h1C, "edit_1c");
    key(0, 8'h32, "edit_32");
    key(0, Bksp, "edit_bksp");
    key(0, 8'h21, "edit_21");
    key(0, Enter, "edit_enter");
    wait_idle(0, "edit");
    check("edit_drained", exp_a.size(), 0);
    check("edit_fill", fill_a, 0);

    // Echo mode on a 4x2 display: line changes and wrap back to row 0.
    for (int i = 0; i < 9; i++) begin
      key(1, 8'(8'h15 + i), "echo_key");
      wait_idle(1, "echo");
    end
    check("echo_drained", exp_b.size(), 0);
    check("echo_fill", fill_b, 0);

    // Reset in the middle of a flush.
    base = chars_a;
    key(0, 8'h1C, "rst_key");
    key(0, 8'h1D, "rst_key");
    key(0, 8'h1E, "rst_key");
    key(0, 8'h1F, "rst_key");
    key(0, Enter, "rst_enter");
    wait_chars(base + 2, "rst_wait");
    #3 resetn = 1'b0;
    #1;
    check("midrst_start", bus_a.LCD_start, 0);
    check("midrst_fill", fill_a, 0);
    check("midrst_busy", busy_a, 1);
    check("midrst_instr", bus_a.LCD_instruction, 0);
    exp_a.delete();
    exp_b.delete();
    mdl_a.delete();
    mdl_b.delete();
    load_init();
    repeat (3) @(negedge CLOCK_50_I);
    resetn = 1'b1;
    wait_idle(0, "reinit_a");
    wait_idle(1, "reinit_b");
    check("reinit_a_drained", exp_a.size(), 0);
    check("reinit_b_drained", exp_b.size(), 0);
    check("reinit_fill", fill_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
